// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage front end: reset PC, FSM state
// encodings and the helper that picks a 32-bit instruction out of the
// 64-bit doubleword returned by the ifu.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef logic [1:0] fc_state_t;

    // IDLE: nothing outstanding, FETCH: outstanding and result kept,
    // KILL: outstanding but the result will be discarded.
    localparam fc_state_t ST_IDLE  = 2'd0;
    localparam fc_state_t ST_FETCH = 2'd1;
    localparam fc_state_t ST_KILL  = 2'd2;

    // pc[2] chooses the upper or lower word of the fetched doubleword.
    function automatic logic [31:0] select_half(input logic upper, input logic [63:0] word);
        logic [31:0] half;
        if (upper) begin
            half = word[63:32];
        end else begin
            half = word[31:0];
        end
        return half;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, inst} pairs between fetch and decode.
// A flush empties it in one edge; a push and a pop in the same cycle are
// allowed even when full because the pop frees the slot first.
module fetch_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [63:0]                wdata,
    output logic [63:0]                rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    // Storage, pointers and occupancy; flush discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 64'h0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage front end. Owns the fetch PC, keeps it stable while a fetch
// is outstanding or the icache is refilling, buffers completed fetches for
// the decoder and applies redirects by flushing the queue and killing any
// in-flight fetch.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [63:0] inst,
    input  logic        inst_r_valid,
    output logic        inst_r_ready,
    input  logic        if_busy,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int            CW = $clog2(QDEPTH);
    localparam logic [CW:0]   QD = (CW + 1)'(QDEPTH);

    fc_state_t     state;
    fc_state_t     next_state;
    logic [31:0]   next_pc;
    logic [31:0]   pend_pc;
    logic [31:0]   next_pend_pc;
    logic          pend_v;
    logic          next_pend_v;
    logic [31:0]   target;
    logic          done;
    logic          push;
    logic          pop;
    logic [63:0]   push_data;
    logic [63:0]   head;
    logic [CW:0]   count;
    logic [CW+1:0] occ_after;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign done      = inst_r_valid && inst_r_ready;
    assign id_valid  = (count != '0);
    // A pop in a redirect cycle is meaningless: the flush wins.
    assign pop       = id_valid && id_ready && !redirect_valid;
    assign push_data = {pc, select_half(pc[2], inst)};
    assign id_pc     = head[63:32];
    assign id_inst   = head[31:0];
    assign occ_after = {1'b0, count} + {{(CW + 1){1'b0}}, push} - {{(CW + 1){1'b0}}, pop};

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (head),
        .count (count)
    );

    // Next-state, PC and pending-redirect logic. Any PC change requested
    // while the icache is busy is parked in pending_pc and applied later.
    always_comb begin
        next_state   = state;
        next_pc      = pc;
        next_pend_pc = pend_pc;
        next_pend_v  = pend_v;
        push         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redirect_valid) begin
                    if (if_busy) begin
                        next_pend_pc = target;
                        next_pend_v  = 1'b1;
                    end else begin
                        next_pc      = target;
                        next_pend_v  = 1'b0;
                    end
                end else if (pend_v) begin
                    if (!if_busy) begin
                        next_pc     = pend_pc;
                        next_pend_v = 1'b0;
                    end else begin
                        next_pend_v = 1'b1;
                    end
                end else if (count < QD) begin
                    next_state = ST_FETCH;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (done) begin
                        next_state = ST_IDLE;
                        if (if_busy) begin
                            next_pend_pc = target;
                            next_pend_v  = 1'b1;
                        end else begin
                            next_pc      = target;
                            next_pend_v  = 1'b0;
                        end
                    end else begin
                        next_state   = ST_KILL;
                        next_pend_pc = target;
                        next_pend_v  = 1'b1;
                    end
                end else if (done) begin
                    push = 1'b1;
                    if (if_busy) begin
                        next_pend_pc = pc + 32'd4;
                        next_pend_v  = 1'b1;
                        next_state   = ST_IDLE;
                    end else begin
                        next_pc = pc + 32'd4;
                        // Keep fetching only if a slot stays reserved for it.
                        if (occ_after < {1'b0, QD}) begin
                            next_state = ST_FETCH;
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end
                end else begin
                    next_state = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (redirect_valid) begin
                    if (done) begin
                        next_state = ST_IDLE;
                        if (if_busy) begin
                            next_pend_pc = target;
                            next_pend_v  = 1'b1;
                        end else begin
                            next_pc      = target;
                            next_pend_v  = 1'b0;
                        end
                    end else begin
                        next_pend_pc = target;
                        next_pend_v  = 1'b1;
                    end
                end else if (done) begin
                    next_state = ST_IDLE;
                    if (!if_busy) begin
                        next_pc     = pend_pc;
                        next_pend_v = 1'b0;
                    end else begin
                        next_pend_v = 1'b1;
                    end
                end else begin
                    next_state = ST_KILL;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, PC and request registers; inst_r_ready follows the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            pend_pc      <= 32'h0;
            pend_v       <= 1'b0;
            inst_r_ready <= 1'b0;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            pend_pc      <= next_pend_pc;
            pend_v       <= next_pend_v;
            inst_r_ready <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a behavioural ifu answers fetches,
// and the decoder-side stream is checked against program order (sequential
// PCs restarting at each redirect target, instruction = code(pc)).
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [63:0] inst = 64'h0;
    logic        inst_r_valid = 1'b0;
    logic        inst_r_ready;
    logic        if_busy = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_r_valid(inst_r_valid),
        .inst_r_ready(inst_r_ready), .if_busy(if_busy), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst)
    );

    int tests_run = 0;
    int fails = 0;

    // reference model / stimulus state
    logic [31:0] exp_pc;
    int          n_consumed = 0;
    logic [31:0] consumed_q[$];
    logic        after_redir, seen_after;
    logic [31:0] first_after_redir;
    int          lat, lat_lo, lat_hi, ready_pct;
    logic        busy_in, redir_req, redir_on_valid;
    logic [31:0] redir_tgt;
    int          n_redir = 0;
    logic        p_rdy, p_done, p_busy, p_idv, p_idr, p_redir;
    logic [31:0] p_pc, p_idpc, p_idinst;

    // Instruction memory content: every word address has a distinct code.
    function automatic logic [31:0] code(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic model_reset();
        exp_pc = RESET_PC;
        p_rdy = 0; p_done = 0; p_busy = 0; p_idv = 0; p_idr = 0; p_redir = 0;
        p_pc = 32'h0; p_idpc = 32'h0; p_idinst = 32'h0;
        lat = lat_lo;
        consumed_q.delete();
        after_redir = 0; seen_after = 0; redir_req = 0; redir_on_valid = 0; busy_in = 0;
        inst_r_valid = 0; if_busy = 0; redirect_valid = 0; id_ready = 0;
    endtask

    // One clock: check invariants, drive inputs for the next edge, update model.
    task automatic cycle();
        logic done;
        @(negedge clk);
        tests_run++;
        if (pc[1:0] !== 2'b00) begin
            fails++; $display("FAIL pc_align pc=%h", pc);
        end
        if ((p_rdy && !p_done) || p_busy) begin
            tests_run++;
            if (pc !== p_pc) begin
                fails++; $display("FAIL pc_hold pc=%h want %h", pc, p_pc);
            end
        end
        if (p_idv && !p_idr && !p_redir) begin
            tests_run++;
            if (id_valid !== 1'b1 || id_pc !== p_idpc || id_inst !== p_idinst) begin
                fails++;
                $display("FAIL id_hold got v=%b %h/%h want 1 %h/%h", id_valid, id_pc, id_inst, p_idpc, p_idinst);
            end
        end
        id_ready = ($urandom_range(99) < ready_pct);
        if_busy = busy_in;
        inst_r_valid = 1'b0;
        inst = {$urandom, $urandom};
        redirect_valid = 1'b0;
        if (inst_r_ready && !busy_in) begin
            if (lat == 0) begin
                inst_r_valid = 1'b1;
                inst = {code((pc & 32'hFFFF_FFF8) + 32'd4), code(pc & 32'hFFFF_FFF8)};
            end else begin
                lat--;
            end
        end
        done = inst_r_valid && inst_r_ready;
        if (done) lat = $urandom_range(lat_hi, lat_lo);
        if (redir_req || (redir_on_valid && done)) begin
            redirect_valid = 1'b1; redirect_pc = redir_tgt;
            redir_req = 0; redir_on_valid = 0; n_redir++;
        end else begin
            redirect_pc = $urandom;
        end
        if (redirect_valid) begin
            exp_pc = redir_tgt & 32'hFFFF_FFFC;
            after_redir = 1;
        end else if (id_valid && id_ready) begin
            tests_run++;
            if (id_pc !== exp_pc || id_inst !== code(exp_pc)) begin
                fails++;
                $display("FAIL stream got %h/%h want %h/%h", id_pc, id_inst, exp_pc, code(exp_pc));
            end
            if (after_redir) begin
                first_after_redir = id_pc; after_redir = 0; seen_after = 1;
            end
            consumed_q.push_back(id_pc);
            exp_pc += 32'd4;
            n_consumed++;
        end
        p_rdy = inst_r_ready; p_done = done; p_busy = if_busy; p_pc = pc;
        p_idv = id_valid; p_idr = id_ready; p_redir = redirect_valid;
        p_idpc = id_pc; p_idinst = id_inst;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (pc !== RESET_PC || inst_r_ready !== 1'b0 || id_valid !== 1'b0 ||
            id_pc !== 32'h0 || id_inst !== 32'h0) begin
            fails++;
            $display("FAIL %s pc=%h rdy=%b idv=%b id=%h/%h want %h 0 0 0/0",
                     tag, pc, inst_r_ready, id_valid, id_pc, id_inst, RESET_PC);
        end
    endtask

    task automatic test_reset();
        lat_lo = 0; lat_hi = 0; ready_pct = 100;
        model_reset();
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset_assert");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset_release");
    endtask

    task automatic test_inorder();
        lat_lo = 0; lat_hi = 0; ready_pct = 100;
        consumed_q.delete();
        for (int i = 0; i < 40 && consumed_q.size() < 3; i++) cycle();
        tests_run++;
        if (consumed_q.size() < 3) begin
            fails++; $display("FAIL inorder_timeout got %0d want 3", consumed_q.size());
        end else if (consumed_q[0] !== 32'h8000_0000 || consumed_q[1] !== 32'h8000_0004 ||
                     consumed_q[2] !== 32'h8000_0008) begin
            fails++;
            $display("FAIL inorder got %h %h %h want 80000000 80000004 80000008",
                     consumed_q[0], consumed_q[1], consumed_q[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pc_full;
        int n0;
        ready_pct = 0;
        for (int i = 0; i < 10; i++) cycle();
        tests_run++;
        if (id_valid !== 1'b1 || inst_r_ready !== 1'b0 || pc !== exp_pc + 32'd4 * QDEPTH) begin
            fails++;
            $display("FAIL full idv=%b rdy=%b pc=%h want 1 0 %h", id_valid, inst_r_ready, pc,
                     exp_pc + 32'd4 * QDEPTH);
        end
        pc_full = pc;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests_run++;
            if (pc !== pc_full || inst_r_ready !== 1'b0) begin
                fails++; $display("FAIL full_hold pc=%h rdy=%b want %h 0", pc, inst_r_ready, pc_full);
            end
        end
        ready_pct = 100;
        n0 = n_consumed;
        for (int i = 0; i < 12; i++) cycle();
        tests_run++;
        if (n_consumed - n0 < 6) begin
            fails++; $display("FAIL resume consumed=%0d want >=6", n_consumed - n0);
        end
    endtask

    task automatic test_redirect_kill();
        int guard;
        lat_lo = 6; lat_hi = 6; ready_pct = 100;
        guard = 0;
        while (!(inst_r_ready && lat == 3) && guard < 60) begin cycle(); guard++; end
        redir_tgt = 32'h8000_1002; redir_req = 1; seen_after = 0;
        cycle();
        cycle();
        tests_run++;
        if (inst_r_ready !== 1'b1) begin
            fails++; $display("FAIL kill_ready got %b want 1", inst_r_ready);
        end
        for (int i = 0; i < 60 && !seen_after; i++) cycle();
        tests_run++;
        if (!seen_after || first_after_redir !== 32'h8000_1000) begin
            fails++; $display("FAIL kill_target seen=%b got %h want 80001000", seen_after, first_after_redir);
        end
    endtask

    task automatic test_redirect_same();
        int r0;
        lat_lo = 0; lat_hi = 2; ready_pct = 100;
        r0 = n_redir;
        redir_tgt = 32'h8000_3004; redir_on_valid = 1; seen_after = 0;
        for (int i = 0; i < 80 && !seen_after; i++) cycle();
        tests_run++;
        if (n_redir == r0 || !seen_after || first_after_redir !== 32'h8000_3004) begin
            fails++;
            $display("FAIL same_cycle_redirect seen=%b got %h want 80003004", seen_after, first_after_redir);
        end
        redir_on_valid = 0;
    endtask

    task automatic test_busy();
        logic [31:0] pc0;
        lat_lo = 2; lat_hi = 2; ready_pct = 100;
        for (int i = 0; i < 5; i++) cycle();
        busy_in = 1; seen_after = 0;
        cycle();
        pc0 = pc;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin redir_tgt = 32'h8000_2000; redir_req = 1; end
            cycle();
            tests_run++;
            if (pc !== pc0) begin
                fails++; $display("FAIL busy_pc cycle %0d pc=%h want %h", i, pc, pc0);
            end
        end
        busy_in = 0;
        for (int i = 0; i < 60 && !seen_after; i++) cycle();
        tests_run++;
        if (!seen_after || first_after_redir !== 32'h8000_2000) begin
            fails++; $display("FAIL busy_target seen=%b got %h want 80002000", seen_after, first_after_redir);
        end
    endtask

    task automatic test_wrap();
        lat_lo = 0; lat_hi = 0; ready_pct = 100;
        redir_tgt = 32'hFFFF_FFFA; redir_req = 1;
        cycle();
        consumed_q.delete();
        for (int i = 0; i < 40 && consumed_q.size() < 4; i++) cycle();
        tests_run++;
        if (consumed_q.size() < 4) begin
            fails++; $display("FAIL wrap_timeout got %0d want 4", consumed_q.size());
        end else if (consumed_q[0] !== 32'hFFFF_FFF8 || consumed_q[1] !== 32'hFFFF_FFFC ||
                     consumed_q[2] !== 32'h0 || consumed_q[3] !== 32'h4) begin
            fails++;
            $display("FAIL wrap got %h %h %h %h want fffffff8 fffffffc 0 4",
                     consumed_q[0], consumed_q[1], consumed_q[2], consumed_q[3]);
        end
    endtask

    task automatic test_random();
        int n0, busy_left;
        lat_lo = 0; lat_hi = 3; ready_pct = 75;
        n0 = n_consumed; busy_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (busy_left > 0) begin busy_left--; busy_in = 1; end
            else if ($urandom_range(49) == 0) begin busy_left = $urandom_range(8, 1); busy_in = 1; end
            else busy_in = 0;
            if ($urandom_range(39) == 0) begin
                redir_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
                if ($urandom_range(1) == 0) redir_req = 1; else redir_on_valid = 1;
            end
            cycle();
        end
        busy_in = 0; redir_on_valid = 0; redir_req = 0;
        for (int i = 0; i < 10; i++) cycle();
        tests_run++;
        if (n_consumed - n0 < 100) begin
            fails++; $display("FAIL random_progress consumed=%0d want >=100", n_consumed - n0);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        lat_lo = 5; lat_hi = 5; ready_pct = 100;
        redir_tgt = 32'h8000_4000; redir_req = 1;
        guard = 0;
        cycle();
        while (!inst_r_ready && guard < 40) begin cycle(); guard++; end
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_mid");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        lat_lo = 1; lat_hi = 1;
        model_reset();
        for (int i = 0; i < 40 && consumed_q.size() < 2; i++) cycle();
        tests_run++;
        if (consumed_q.size() < 2 || consumed_q[0] !== RESET_PC || consumed_q[1] !== RESET_PC + 32'd4) begin
            fails++; $display("FAIL restart count=%0d want %h then %h", consumed_q.size(), RESET_PC, RESET_PC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_inorder();
        test_backpressure();
        test_redirect_kill();
        test_redirect_same();
        test_busy();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
